// File: rtl/conv1_buf_8b.sv
// ---------------------------------------------------------------------------
// conv1_buf_8b
//
// Sliding 3x3 window generator for the first convolution layer. Pixels
// arrive in raster order, one per valid_in cycle. A shift buffer two image
// rows plus three bytes long keeps enough history to present a full 3x3
// neighbourhood whenever the incoming pixel completes one. Windows that
// would straddle a row wrap are suppressed, and so are windows in the first
// two rows. The counters wrap at the end of the frame, so consecutive frames
// can stream with no gap and never share a window.
//
// Ports
//   clk            : single clock, rising edge
//   rst_n          : asynchronous active-low reset
//   valid_in       : pixel_in carries a pixel this cycle (no back-pressure)
//   pixel_in[7:0]  : unsigned pixel, row-major, top-left first
//   pixel_0..8     : registered 3x3 window, row-major (0 = top-left)
//   valid_out_buf  : window outputs valid this cycle (one cycle per window)
//   frame_done     : pulses with the bottom-right window of each frame
// ---------------------------------------------------------------------------
module conv1_buf_8b #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int KERNEL_SIZE = 3    // only 3 is supported
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic [7:0] pixel_in,
    output logic [7:0] pixel_0,
    output logic [7:0] pixel_1,
    output logic [7:0] pixel_2,
    output logic [7:0] pixel_3,
    output logic [7:0] pixel_4,
    output logic [7:0] pixel_5,
    output logic [7:0] pixel_6,
    output logic [7:0] pixel_7,
    output logic [7:0] pixel_8,
    output logic       valid_out_buf,
    output logic       frame_done
);

    localparam int NTAPS   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int BUF_LEN = (KERNEL_SIZE - 1) * IMG_W + KERNEL_SIZE;
    localparam int CW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW      = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);

    // r_buf[0] holds the previously accepted pixel; r_buf[d-1] holds the
    // pixel accepted d cycles (of valid_in) before the current one.
    logic [7:0]    r_buf [BUF_LEN];
    logic [CW-1:0] r_col_cnt;
    logic [RW-1:0] r_row_cnt;
    logic [7:0]    r_win [NTAPS];
    logic          r_valid;
    logic          r_frame_done;

    logic [7:0]    w_tap [NTAPS];
    logic          w_col_last;
    logic          w_row_last;
    logic          w_win_event;

    assign w_col_last  = (r_col_cnt == COL_LAST);
    assign w_row_last  = (r_row_cnt == ROW_LAST);
    assign w_win_event = valid_in && (r_row_cnt >= ROW_FIRST) && (r_col_cnt >= COL_FIRST);

    // Tap k sits (K-1-k/K) rows and (K-1-k%K) columns behind the incoming
    // pixel, i.e. that many raster positions back. The bottom-right tap is
    // the incoming pixel itself, so the window is complete on the event edge.
    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        localparam int DIST = (KERNEL_SIZE - 1 - k / KERNEL_SIZE) * IMG_W
                            + (KERNEL_SIZE - 1 - k % KERNEL_SIZE);
        if (DIST == 0) begin : g_live
            assign w_tap[k] = pixel_in;
        end else begin : g_hist
            assign w_tap[k] = r_buf[DIST-1];
        end
    end

    // NOTE: the line buffer is reset along with everything else so that a
    // frame started after reset can never expose stale bytes; this costs a
    // reset net on every flop, which is acceptable at this size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_LEN; i++) begin
                r_buf[i] <= '0;
            end
        end else if (valid_in) begin
            // NOTE: non-blocking assignments make every element read its
            // neighbour's pre-edge value, so the loop order is irrelevant.
            r_buf[0] <= pixel_in;
            for (int i = 1; i < BUF_LEN; i++) begin
                r_buf[i] <= r_buf[i-1];
            end
        end
    end

    // Raster position of the pixel being accepted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (valid_in) begin
            if (w_col_last) begin
                r_col_cnt <= '0;
                r_row_cnt <= w_row_last ? '0 : r_row_cnt + 1'b1;
            end else begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    // Window outputs only load on an event and otherwise hold; the valid and
    // frame_done flags are recomputed every cycle so they pulse exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_win[k] <= '0;
            end
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid      <= w_win_event;
            r_frame_done <= w_win_event && w_col_last && w_row_last;
            if (w_win_event) begin
                for (int k = 0; k < NTAPS; k++) begin
                    r_win[k] <= w_tap[k];
                end
            end
        end
    end

    assign pixel_0       = r_win[0];
    assign pixel_1       = r_win[1];
    assign pixel_2       = r_win[2];
    assign pixel_3       = r_win[3];
    assign pixel_4       = r_win[4];
    assign pixel_5       = r_win[5];
    assign pixel_6       = r_win[6];
    assign pixel_7       = r_win[7];
    assign pixel_8       = r_win[8];
    assign valid_out_buf = r_valid;
    assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_conv1_buf_8b.sv
// ---------------------------------------------------------------------------
// tb_conv1_buf_8b
//
// Self-checking bench for conv1_buf_8b. A reference model stores the frame
// as a 2-D image indexed by a linear pixel count and derives each expected
// 3x3 window directly from image coordinates. Every negative clock edge the
// DUT outputs are compared with the model; literal ramp windows pin the
// model itself. Scenarios: reset, ramp, stalled ramp, back-to-back frames,
// random pixels with random stalls, and a mid-frame asynchronous reset.
// ---------------------------------------------------------------------------
module tb_conv1_buf_8b;

    localparam int W = 28;
    localparam int H = 28;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] pixel_in = '0;
    logic [7:0] pix_o [9];
    logic       valid_out_buf;
    logic       frame_done;

    int n_checks = 0;
    int n_err    = 0;

    conv1_buf_8b #(.IMG_W(W), .IMG_H(H), .KERNEL_SIZE(3)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .pixel_in      (pixel_in),
        .pixel_0       (pix_o[0]),
        .pixel_1       (pix_o[1]),
        .pixel_2       (pix_o[2]),
        .pixel_3       (pix_o[3]),
        .pixel_4       (pix_o[4]),
        .pixel_5       (pix_o[5]),
        .pixel_6       (pix_o[6]),
        .pixel_7       (pix_o[7]),
        .pixel_8       (pix_o[8]),
        .valid_out_buf (valid_out_buf),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] pack(input logic [7:0] w [9]);
        return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8]};
    endfunction

    // ---------------- reference model ----------------
    logic [7:0] img [H][W];
    logic [7:0] exp_win [9];
    logic       exp_valid;
    logic       exp_fd;
    int         m_n;
    int         m_r;
    int         m_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n       = 0;
            exp_valid = 1'b0;
            exp_fd    = 1'b0;
            for (int k = 0; k < 9; k++) exp_win[k] = '0;
        end else if (valid_in) begin
            m_r = m_n / W;
            m_c = m_n % W;
            img[m_r][m_c] = pixel_in;
            if (m_r >= 2 && m_c >= 2) begin
                for (int k = 0; k < 9; k++)
                    exp_win[k] = img[m_r - 2 + k / 3][m_c - 2 + k % 3];
                exp_valid = 1'b1;
                exp_fd    = (m_n == N - 1);
            end else begin
                exp_valid = 1'b0;
                exp_fd    = 1'b0;
            end
            m_n = (m_n + 1) % N;
        end else begin
            exp_valid = 1'b0;
            exp_fd    = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    logic [71:0] win_log [$];
    int          fd_cnt = 0;
    logic [71:0] fd_win = '0;

    always @(negedge clk) begin
        check("valid_out_buf", {71'd0, valid_out_buf}, {71'd0, exp_valid});
        check("frame_done",    {71'd0, frame_done},    {71'd0, exp_fd});
        check("window",        pack(pix_o),            pack(exp_win));
        if (valid_out_buf) win_log.push_back(pack(pix_o));
        if (frame_done) begin
            fd_cnt++;
            fd_win = pack(pix_o);
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [71:0] FIRST_WIN = {8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58};
    localparam logic [71:0] LAST_WIN  = {8'd213, 8'd214, 8'd215, 8'd241, 8'd242, 8'd243, 8'd13, 8'd14, 8'd15};

    task automatic send(input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        valid_in = v;
        pixel_in = d;
    endtask

    task automatic feed(input int count, input bit ramp, input bit stall);
        for (int n = 0; n < count; n++) begin
            while (stall && $urandom_range(99) < 50) send(1'b0, 8'($urandom));
            send(1'b1, ramp ? 8'(n % 256) : 8'($urandom));
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) send(1'b0, 8'($urandom));
    endtask

    int base;
    int fd_base;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset valid", {71'd0, valid_out_buf}, 72'd0);
        check("reset frame_done", {71'd0, frame_done}, 72'd0);
        check("reset window", pack(pix_o), 72'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Continuous ramp frame
        base = win_log.size(); fd_base = fd_cnt;
        feed(N, 1'b1, 1'b0); idle(2);
        check("ramp count", 72'(win_log.size() - base), 72'd676);
        check("ramp fd count", 72'(fd_cnt - fd_base), 72'd1);
        check("ramp first window", win_log[base], FIRST_WIN);
        check("ramp last window", fd_win, LAST_WIN);

        // Ramp with 50% stalls
        base = win_log.size(); fd_base = fd_cnt;
        feed(N, 1'b1, 1'b1); idle(2);
        check("stall count", 72'(win_log.size() - base), 72'd676);
        check("stall fd count", 72'(fd_cnt - fd_base), 72'd1);
        check("stall first window", win_log[base], FIRST_WIN);
        check("stall last window", fd_win, LAST_WIN);

        // Two frames back to back
        base = win_log.size(); fd_base = fd_cnt;
        feed(N, 1'b1, 1'b0); feed(N, 1'b1, 1'b0); idle(2);
        check("b2b count", 72'(win_log.size() - base), 72'd1352);
        check("b2b fd count", 72'(fd_cnt - fd_base), 72'd2);
        check("b2b second first window", win_log[base + 676], FIRST_WIN);
        check("b2b last window", fd_win, LAST_WIN);

        // Random pixels with random stalls
        base = win_log.size(); fd_base = fd_cnt;
        feed(N, 1'b0, 1'b1); idle(2);
        check("random count", 72'(win_log.size() - base), 72'd676);
        check("random fd count", 72'(fd_cnt - fd_base), 72'd1);

        // Mid-frame asynchronous reset after 400 pixels
        feed(400, 1'b1, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async reset valid", {71'd0, valid_out_buf}, 72'd0);
        check("async reset frame_done", {71'd0, frame_done}, 72'd0);
        check("async reset window", pack(pix_o), 72'd0);
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = win_log.size(); fd_base = fd_cnt;
        feed(N, 1'b1, 1'b0); idle(2);
        check("post-reset count", 72'(win_log.size() - base), 72'd676);
        check("post-reset fd count", 72'(fd_cnt - fd_base), 72'd1);
        check("post-reset first window", win_log[base], FIRST_WIN);
        check("post-reset last window", fd_win, LAST_WIN);

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
